if_fetch_stage: RTL and testbench

Instruction-fetch stage of the MIPS32 pipeline: owns the PC register, drives the instruction-memory request, and produces the IF/ID pipeline register consumed by decode and by the hazard handling unit. It obeys the hazard unit's `PC_Enable` / `IF_ID_Pipeline_Enable` stall outputs. Branches and jumps resolved in ID redirect fetch with architected one-instruction delay-slot semantics. A wait-state memory interface is supported through a one-entry hold buffer and a pending-redirect register.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/if_fetch_stage_if.sv | 24 ++
 rtl/if_hold_buffer.sv | 38 +++
 rtl/if_fetch_stage.sv | 138 +++++++++++++
 tb/tb_if_fetch_stage.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: widths, the bubble encoding and the fetch FSM states.
package mips_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [PC_W-1:0] INSTR_NOP = 32'h0000_0000;

  localparam logic [PC_W-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    RST_IDLE,
    FETCH,
    HOLD
  } fetch_state_t;

  // Fetch addresses are always word aligned; low bits of any incoming address are dropped.
  function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface if_fetch_stage_if;
  import mips_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;
  logic [PC_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/if_hold_buffer.sv
// One-entry skid register for an instruction that completed while decode was stalled.
module if_hold_buffer
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [PC_W-1:0] instr_i,
  input  logic [PC_W-1:0] pc_plus4_i,
  output logic            valid_o,
  output logic [PC_W-1:0] instr_o,
  output logic [PC_W-1:0] pc_plus4_o
);

  logic            valid_q;
  logic [PC_W-1:0] instr_q;
  logic [PC_W-1:0] pc_plus4_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_plus4_q <= '0;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      instr_q    <= instr_i;
      pc_plus4_q <= pc_plus4_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS32 instruction-fetch stage: PC register, imem request and IF/ID register, with
// delay-slot redirects and wait-state tolerance via a hold buffer and a pending redirect.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                PC_Enable,
  input  logic                IF_ID_Pipeline_Enable,
  input  logic                ID_Redirect,
  input  logic [PC_W-1:0]     ID_Redirect_Target,
  if_fetch_stage_if.master    imem,
  output logic [PC_W-1:0]     IF_ID_Instr,
  output logic [PC_W-1:0]     IF_ID_PC_Plus4,
  output logic                IF_ID_Valid,
  output logic [4:0]          IF_ID_Reg_Rs,
  output logic [4:0]          IF_ID_Reg_Rt
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            redirect_pending_q, redirect_pending_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [PC_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0] pc_plus4_q, pc_plus4_d;
  logic            valid_q, valid_d;

  logic            adv;
  logic            done;
  logic [PC_W-1:0] pc_plus4;
  logic            hold_load, hold_clear, hold_valid;
  logic [PC_W-1:0] hold_instr, hold_pc_plus4;

  assign adv      = PC_Enable & IF_ID_Pipeline_Enable;
  assign done     = imem.imem_req & imem.imem_ready;
  assign pc_plus4 = pc_q + 32'd4;

  if_hold_buffer u_hold_buffer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (hold_load),
    .clear_i    (hold_clear),
    .instr_i    (imem.imem_rdata),
    .pc_plus4_i (pc_plus4),
    .valid_o    (hold_valid),
    .instr_o    (hold_instr),
    .pc_plus4_o (hold_pc_plus4)
  );

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    redirect_pending_d = redirect_pending_q;
    redirect_pc_d      = redirect_pc_q;
    instr_d            = instr_q;
    pc_plus4_d         = pc_plus4_q;
    valid_d            = valid_q;
    hold_load          = 1'b0;
    hold_clear         = 1'b0;
    unique case (state_q)
      RST_IDLE: state_d = FETCH;
      FETCH: begin
        if (done) begin
          // ID_Redirect only counts when the pipeline advances.
          if (adv && ID_Redirect) begin
            pc_d = pc_align(ID_Redirect_Target);
          end else if (redirect_pending_q) begin
            pc_d = redirect_pc_q;
          end else begin
            pc_d = pc_align(pc_plus4);
          end
          redirect_pending_d = 1'b0;
          if (adv) begin
            instr_d    = imem.imem_rdata;
            pc_plus4_d = pc_plus4;
            valid_d    = 1'b1;
          end else begin
            hold_load = 1'b1;
            state_d   = HOLD;
          end
        end else if (adv) begin
          instr_d = INSTR_NOP;
          valid_d = 1'b0;
          // The outstanding fetch is the delay slot; retarget after it lands.
          if (ID_Redirect) begin
            redirect_pending_d = 1'b1;
            redirect_pc_d      = pc_align(ID_Redirect_Target);
          end
        end
      end
      HOLD: begin
        if (adv && hold_valid) begin
          instr_d    = hold_instr;
          pc_plus4_d = hold_pc_plus4;
          valid_d    = 1'b1;
          hold_clear = 1'b1;
          state_d    = FETCH;
          if (ID_Redirect) begin
            pc_d = pc_align(ID_Redirect_Target);
          end
        end
      end
      default: state_d = RST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= RST_IDLE;
      pc_q               <= RESET_PC;
      redirect_pending_q <= 1'b0;
      redirect_pc_q      <= '0;
      instr_q            <= INSTR_NOP;
      pc_plus4_q         <= '0;
      valid_q            <= 1'b0;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      redirect_pending_q <= redirect_pending_d;
      redirect_pc_q      <= redirect_pc_d;
      instr_q            <= instr_d;
      pc_plus4_q         <= pc_plus4_d;
      valid_q            <= valid_d;
    end
  end

  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;

  assign IF_ID_Instr    = instr_q;
  assign IF_ID_PC_Plus4 = pc_plus4_q;
  assign IF_ID_Valid    = valid_q;
  assign IF_ID_Reg_Rs   = instr_q[25:21];
  assign IF_ID_Reg_Rt   = instr_q[20:16];

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus random stalls, wait states
// and redirects, checked against an architectural model of the delivered instruction stream.
module tb_if_fetch_stage;
  import mips_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PC_Enable = 1'b1;
  logic        IF_ID_Pipeline_Enable = 1'b1;
  logic        ID_Redirect = 1'b0;
  logic [31:0] ID_Redirect_Target = '0;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PC_Plus4;
  logic        IF_ID_Valid;
  logic [4:0]  IF_ID_Reg_Rs;
  logic [4:0]  IF_ID_Reg_Rt;

  if_fetch_stage_if bus ();

  if_fetch_stage #(
    .RESET_PC (RST_PC)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .PC_Enable             (PC_Enable),
    .IF_ID_Pipeline_Enable (IF_ID_Pipeline_Enable),
    .ID_Redirect           (ID_Redirect),
    .ID_Redirect_Target    (ID_Redirect_Target),
    .imem                  (bus),
    .IF_ID_Instr           (IF_ID_Instr),
    .IF_ID_PC_Plus4        (IF_ID_PC_Plus4),
    .IF_ID_Valid           (IF_ID_Valid),
    .IF_ID_Reg_Rs          (IF_ID_Reg_Rs),
    .IF_ID_Reg_Rt          (IF_ID_Reg_Rt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_rdata = bus.imem_ready ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Architectural model: address of the next instruction to be delivered, whether a fetched
  // word is parked during a stall, and redirect progress (1: delay slot next, 2: target next).
  logic [31:0] exp_pc;
  bit          buffered;
  int          rd_st;
  logic [31:0] rd_tgt;
  int          delivered = 0;

  task automatic model_reset();
    exp_pc   = RST_PC;
    buffered = 1'b0;
    rd_st    = 0;
    rd_tgt   = '0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_req"},   32'(bus.imem_req), 32'd0);
    check_eq({pfx, "_addr"},  bus.imem_addr, RST_PC);
    check_eq({pfx, "_instr"}, IF_ID_Instr, 32'd0);
    check_eq({pfx, "_pc4"},   IF_ID_PC_Plus4, 32'd0);
    check_eq({pfx, "_valid"}, 32'(IF_ID_Valid), 32'd0);
  endtask

  // One clock cycle: drive inputs at posedge+1, sample results at the next posedge+1.
  task automatic step(input bit pce, input bit ife, input bit rdy, input bit redir,
                      input logic [31:0] tgt);
    bit          adv, done, exp_valid, s_req, s_valid;
    logic [31:0] s_instr, s_pc4, s_addr, w;
    PC_Enable             = pce;
    IF_ID_Pipeline_Enable = ife;
    bus.imem_ready        = rdy;
    ID_Redirect           = redir;
    ID_Redirect_Target    = tgt;
    #1;
    adv     = pce & ife;
    s_req   = bus.imem_req;
    done    = s_req & rdy;
    s_addr  = bus.imem_addr;
    s_instr = IF_ID_Instr;
    s_pc4   = IF_ID_PC_Plus4;
    s_valid = IF_ID_Valid;
    if (adv && redir) begin
      rd_st  = 1;
      rd_tgt = tgt & 32'hFFFF_FFFC;
    end
    @(posedge clk);
    #1;
    if (s_req && !rdy) begin
      check_eq("wait_req_held", 32'(bus.imem_req), 32'd1);
      check_eq("wait_addr_stable", bus.imem_addr, s_addr);
    end
    if (!adv) begin
      check_eq("stall_instr", IF_ID_Instr, s_instr);
      check_eq("stall_pc4", IF_ID_PC_Plus4, s_pc4);
      check_eq("stall_valid", 32'(IF_ID_Valid), 32'(s_valid));
      if (done) buffered = 1'b1;
    end else begin
      exp_valid = done | buffered;
      buffered  = 1'b0;
      check_eq("valid", 32'(IF_ID_Valid), 32'(exp_valid));
      if (exp_valid) begin
        w = mem_word(exp_pc);
        check_eq("instr", IF_ID_Instr, w);
        check_eq("pc_plus4", IF_ID_PC_Plus4, exp_pc + 32'd4);
        check_eq("rs", 32'(IF_ID_Reg_Rs), 32'(w[25:21]));
        check_eq("rt", 32'(IF_ID_Reg_Rt), 32'(w[20:16]));
        delivered++;
        if (rd_st == 1) begin
          exp_pc = rd_tgt;
          rd_st  = 2;
        end else begin
          if (rd_st == 2) rd_st = 0;
          exp_pc = exp_pc + 32'd4;
        end
      end else begin
        check_eq("bubble_instr", IF_ID_Instr, 32'd0);
        check_eq("bubble_pc4", IF_ID_PC_Plus4, s_pc4);
      end
    end
  endtask

  task automatic rand_step();
    bit          st, pce, ife, rdy, redir;
    logic [31:0] tgt;
    st    = ($urandom_range(99) < 25);
    pce   = 1'b1;
    ife   = 1'b1;
    redir = 1'b0;
    tgt   = $urandom;
    if (st) begin
      case ($urandom_range(2))
        0:       begin pce = 1'b0; ife = 1'b0; end
        1:       pce = 1'b0;
        default: ife = 1'b0;
      endcase
      redir = 1'($urandom_range(1));
    end else if (IF_ID_Valid && rd_st == 0 && $urandom_range(99) < 20) begin
      redir = 1'b1;
      case ($urandom_range(3))
        0:       tgt = 32'h0000_1000;
        1:       tgt = 32'hFFFF_FFF8;
        default: tgt = $urandom;
      endcase
    end
    rdy = ($urandom_range(99) < 60);
    step(pce, ife, rdy, redir, tgt);
  endtask

  initial begin
    bus.imem_ready = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("post_reset_idle_req", 32'(bus.imem_req), 32'd0);

    // Zero-wait streaming from RESET_PC.
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check_eq("first_req", 32'(bus.imem_req), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0);

    // Three-cycle hazard stall with zero-wait memory.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0);

    // Two wait states produce two bubbles.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);

    // Redirect while the delay-slot fetch is waiting.
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1000);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0);

    // Stall on completion (HOLD), ignored redirect while stalled, redirect on release, wrap.
    step(1'b0, 1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_5554);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0);

    // Reset in the middle of a waiting fetch.
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 1500; i++) rand_step();

    check_eq("progress", 32'(delivered > 400), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
